// File: rtl/alu_iterative.sv
// alu_iterative: registered ALU with single-cycle ops and an iterative radix-2 multiply/divide unit
module alu_iterative #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t             r_state, w_next;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_b, r_result;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_cnt;
  logic               r_zero, r_neg_q, r_neg_r;
  logic               w_accept, w_div, w_iter, w_sgn, w_special, w_start, w_last;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_alu, w_special_res, w_imm, w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_quo, w_rem, w_iter_res;
  logic [WIDTH:0]     w_sum, w_trial;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt;
  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_div     = ALUControl[3:2] == 2'b11;
  assign w_iter    = ALUControl[3] & (ALUControl[2] | ALUControl[1]);
  assign w_sgn     = w_div & ~ALUControl[0];
  assign w_special = w_div & ((B == '0) | (w_sgn & (A == MIN) & (B == '1)));
  assign w_start   = w_iter & ~w_special;
  assign w_sh      = B[SHW-1:0];
  assign w_a_mag   = (w_sgn & A[WIDTH-1]) ? -A : A;
  assign w_b_mag   = (w_sgn & B[WIDTH-1]) ? -B : B;
  assign w_special_res = (B == '0) ? (ALUControl[1] ? A : '1) : (ALUControl[1] ? '0 : MIN);
  assign w_imm     = w_special ? w_special_res : w_alu;
  // single-cycle operations
  always_comb begin
    w_alu = '0;
    case (ALUControl)
      4'b0000: w_alu = A + B;
      4'b0001: w_alu = A << w_sh;
      4'b0010: w_alu = A - B;
      4'b0011: w_alu = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      4'b0100: w_alu = A ^ B;
      4'b0101: w_alu = A >> w_sh;
      4'b0110: w_alu = A | B;
      4'b0111: w_alu = A & B;
      4'b1000: w_alu = WIDTH'($signed(A) >>> w_sh);
      4'b1001: w_alu = {{(WIDTH-1){1'b0}}, A < B};
      default: w_alu = '0;
    endcase
  end
  // multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_nxt  = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
  assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
  assign w_div_nxt  = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_acc_nxt  = r_op[2] ? w_div_nxt : w_mul_nxt;
  assign w_quo      = r_neg_q ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
  assign w_rem      = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
  assign w_iter_res = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                              : (r_op[0] ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0]);
  assign w_last     = r_cnt == SHW'(WIDTH-1);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = w_start ? BUSY : DONE;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept) begin
      r_op  <= ALUControl[2:0];
      r_cnt <= '0;
      if (w_start) begin
        r_acc   <= {{WIDTH{1'b0}}, w_div ? w_a_mag : B};
        r_b     <= w_div ? w_b_mag : A;
        r_neg_q <= w_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
        r_neg_r <= w_sgn & A[WIDTH-1];
      end else begin
        r_result <= w_imm;
        r_zero   <= w_imm == '0;
      end
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + SHW'(1);
      if (w_last) begin
        r_result <= w_iter_res;
        r_zero   <= w_iter_res == '0;
      end
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign ALUResult = r_result;
  assign Zero      = r_zero;
endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: directed self-checking bench for alu_iterative at WIDTH=32 and WIDTH=16
module tb_alu_iterative;
  logic        clk = 1'b0;
  logic        rst_n, iv32, iv16, ordy, sel;
  logic [31:0] A, B;
  logic [3:0]  ctl;
  logic        ir32, ov32, z32, ir16, ov16, z16;
  logic [31:0] r32;
  logic [15:0] r16;
  logic        ir, ov, zr;
  logic [31:0] res;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  alu_iterative #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(A), .B(B),
    .ALUControl(ctl), .out_valid(ov32), .out_ready(ordy), .ALUResult(r32), .Zero(z32)
  );
  alu_iterative #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(A[15:0]), .B(B[15:0]),
    .ALUControl(ctl), .out_valid(ov16), .out_ready(ordy), .ALUResult(r16), .Zero(z16)
  );
  assign ir  = sel ? ir16 : ir32;
  assign ov  = sel ? ov16 : ov32;
  assign zr  = sel ? z16 : z32;
  assign res = sel ? {16'h0, r16} : r32;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, ir}, 32'd1);
    ctl = c; A = a; B = b;
    if (sel) iv16 = 1'b1; else iv32 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; iv32 = 1'b0;
    lat = 0;
    do begin
      lat++;
      @(negedge clk);
    end while (!ov && lat < 200);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " result"}, res, exp);
    chk({tag, " zero"}, {31'd0, zr}, {31'd0, exp == 32'd0});
    if (ordy) begin
      @(posedge clk); #1;
      chk({tag, " out_valid drop"}, {31'd0, ov}, 32'd0);
      chk({tag, " back to idle"}, {31'd0, ir}, 32'd1);
    end
  endtask
  task automatic backpressure(input string tag, input logic [3:0] c, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input int elat);
    ordy = 1'b0;
    run(tag, c, a, b, exp, elat);
    for (int i = 0; i < 5; i++) begin
      chk({tag, " hold valid"}, {31'd0, ov}, 32'd1);
      chk({tag, " hold result"}, res, exp);
      chk({tag, " hold in_ready"}, {31'd0, ir}, 32'd0);
      if (i == 0) begin
        ctl = 4'b0000; A = 32'd9; B = 32'd9;
        if (sel) iv16 = 1'b1; else iv32 = 1'b1;
      end
      @(negedge clk);
    end
    iv16 = 1'b0; iv32 = 1'b0;
    chk({tag, " still held"}, res, exp);
    ordy = 1'b1;
    @(posedge clk); #1;
    chk({tag, " release valid"}, {31'd0, ov}, 32'd0);
    chk({tag, " release idle"}, {31'd0, ir}, 32'd1);
  endtask
  initial begin
    rst_n = 1'b0; iv32 = 1'b0; iv16 = 1'b0; ordy = 1'b1; sel = 1'b0;
    A = '0; B = '0; ctl = '0;
    repeat (2) @(negedge clk);
    chk("rst32 in_ready", {31'd0, ir32}, 32'd1);
    chk("rst32 out_valid", {31'd0, ov32}, 32'd0);
    chk("rst32 result", r32, 32'd0);
    chk("rst32 zero", {31'd0, z32}, 32'd1);
    chk("rst16 in_ready", {31'd0, ir16}, 32'd1);
    chk("rst16 result", {16'd0, r16}, 32'd0);
    chk("rst16 zero", {31'd0, z16}, 32'd1);
    rst_n = 1'b1;
    run("ADD wrap", 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run("SUB", 4'b0010, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    run("SLL shamt", 4'b0001, 32'h1, 32'h3F, 32'h80000000, 1);
    run("SRL shamt", 4'b0101, 32'h80000000, 32'h21, 32'h40000000, 1);
    run("SRA", 4'b1000, 32'h80000000, 32'd4, 32'hF8000000, 1);
    run("XOR", 4'b0100, 32'hF0F0, 32'hFF00, 32'h0FF0, 1);
    run("OR", 4'b0110, 32'hF0F0, 32'hFF00, 32'hFFF0, 1);
    run("AND", 4'b0111, 32'hF0F0, 32'hFF00, 32'hF000, 1);
    run("SLT", 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
    run("SLTU", 4'b1001, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
    run("MUL", 4'b1010, 32'h12345678, 32'h10, 32'h23456780, 33);
    run("MULHU", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("DIV", 4'b1100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("REM", 4'b1110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("DIVU", 4'b1101, 32'd100, 32'd7, 32'd14, 33);
    run("REMU", 4'b1111, 32'd100, 32'd7, 32'd2, 33);
    run("DIVU by0", 4'b1101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run("REM by0", 4'b1110, 32'd5, 32'd0, 32'd5, 1);
    run("DIV ovf", 4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("REM ovf", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    @(negedge clk);
    ctl = 4'b1101; A = 32'd100; B = 32'd7; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", {31'd0, ir32}, 32'd1);
    chk("midrst out_valid", {31'd0, ov32}, 32'd0);
    chk("midrst result", r32, 32'd0);
    chk("midrst zero", {31'd0, z32}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 10 == 0) begin
        chk("postrst no valid", {31'd0, ov32}, 32'd0);
        chk("postrst in_ready", {31'd0, ir32}, 32'd1);
      end
    end
    run("DIVU after rst", 4'b1101, 32'd100, 32'd7, 32'd14, 33);
    backpressure("BP32 MUL", 4'b1010, 32'h12345678, 32'h10, 32'h23456780, 33);
    run("BP32 next", 4'b0000, 32'd2, 32'd3, 32'd5, 1);
    sel = 1'b1;
    backpressure("BP16 MUL", 4'b1010, 32'h1234, 32'h10, 32'h2340, 17);
    run("BP16 next", 4'b1101, 32'd100, 32'd7, 32'd14, 17);
    run("W16 SRA", 4'b1000, 32'h8000, 32'd4, 32'hF800, 1);
    run("W16 MULHU", 4'b1011, 32'hFFFF, 32'hFFFF, 32'hFFFE, 17);
    run("W16 DIV", 4'b1100, 32'hFFF9, 32'd2, 32'hFFFD, 17);
    run("W16 DIV ovf", 4'b1100, 32'h8000, 32'hFFFF, 32'h8000, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
